axi_dc_token_writer: RTL and testbench

- Single-clock-domain writer end of the token/read-pointer clock-domain-crossing channel used for every AXI channel crossing between the SoC and cluster domains.
- Accepts a valid/ready stream and stores beats in a BUFFER_WIDTH-entry register buffer.
- Publishes a Johnson-coded write token and the full buffer contents.
- Consumes the far-side read pointer, which arrives asynchronously, to produce backpressure.
- One instance per AXI channel (AW, AR, W, R, B) on the sending side of a domain crossing.

---
 rtl/axi_dc_token_writer.sv | 129 ++++++++++++
 tb/tb_axi_dc_token_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axi_dc_token_writer.sv
// Writer end of the token / read-pointer clock-domain-crossing channel.
// Beats from a valid/ready stream are stored in a register buffer. A Johnson-coded
// write token and the whole buffer are published to the far domain. The far-side
// Johnson read pointer is brought in through a two-flop synchronizer and used to
// produce backpressure and a local fill level.
//
// Ports:
//   clk_i          domain clock
//   rstn_i         asynchronous active-low reset
//   valid_i        upstream beat valid
//   data_i         upstream beat payload
//   ready_o        beat accepted when valid_i && ready_o at the rising edge
//   writetoken_o   Johnson-coded write token to the far domain
//   buffer_o       flattened buffer, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   readpointer_i  Johnson-coded read pointer from the far domain (asynchronous)
//   level_o        occupied entries as seen locally (0..BUFFER_WIDTH)
module axi_dc_token_writer #(
    parameter int unsigned BUFFER_WIDTH = 8,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               valid_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic                               ready_o,
    output logic [BUFFER_WIDTH-1:0]            writetoken_o,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] buffer_o,
    input  logic [BUFFER_WIDTH-1:0]            readpointer_i,
    output logic [$clog2(BUFFER_WIDTH):0]      level_o
);

    localparam int unsigned LevelWidth = $clog2(BUFFER_WIDTH) + 1;

    function automatic int unsigned popcount(input logic [BUFFER_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Position of a Johnson code in its 2*BUFFER_WIDTH-long sequence.
    function automatic int unsigned token_count(input logic [BUFFER_WIDTH-1:0] t);
        return t[BUFFER_WIDTH-1] ? BUFFER_WIDTH + popcount(~t) : popcount(t);
    endfunction

    // Buffer slot addressed by a Johnson code (count modulo BUFFER_WIDTH).
    function automatic int unsigned token_idx(input logic [BUFFER_WIDTH-1:0] t);
        return t[BUFFER_WIDTH-1] ? popcount(~t) : popcount(t);
    endfunction

    logic [BUFFER_WIDTH-1:0] writetoken_q, writetoken_d;
    logic [BUFFER_WIDTH-1:0] rp_s1_q, rp_sync_q;
    logic [DATA_WIDTH-1:0]   buffer_q [BUFFER_WIDTH];

    logic        full;
    logic        write_en;
    int unsigned wr_idx;
    int unsigned wr_cnt;
    int unsigned rd_cnt;
    int unsigned level_int;

    // Status is derived from registers only, so ready_o never depends on valid_i.
    always_comb begin
        full      = (writetoken_q == ~rp_sync_q);
        ready_o   = ~full;
        write_en  = valid_i && ready_o;
        wr_idx    = token_idx(writetoken_q);
        wr_cnt    = token_count(writetoken_q);
        rd_cnt    = token_count(rp_sync_q);
        // Difference of positions modulo 2*BUFFER_WIDTH.
        level_int = (wr_cnt >= rd_cnt) ? (wr_cnt - rd_cnt)
                                       : (wr_cnt + 2 * BUFFER_WIDTH - rd_cnt);
        level_o   = level_int[LevelWidth-1:0];
    end

    always_comb begin
        writetoken_d = writetoken_q;
        if (write_en) begin
            writetoken_d = {writetoken_q[BUFFER_WIDTH-2:0], ~writetoken_q[BUFFER_WIDTH-1]};
        end
    end

    // Two-flop synchronizer; the only place readpointer_i is sampled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rp_s1_q   <= '0;
            rp_sync_q <= '0;
        end else begin
            rp_s1_q   <= readpointer_i;
            rp_sync_q <= rp_s1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            writetoken_q <= '0;
        end else begin
            writetoken_q <= writetoken_d;
        end
    end

    // Data and token update on the same edge; the far side synchronizes the token,
    // so the slot contents are settled long before it reads them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
                buffer_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
                if (write_en && (wr_idx == i)) begin
                    buffer_q[i] <= data_i;
                end
            end
        end
    end

    always_comb begin
        buffer_o = '0;
        for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
            buffer_o[i*DATA_WIDTH +: DATA_WIDTH] = buffer_q[i];
        end
    end

    assign writetoken_o = writetoken_q;

endmodule

// File: tb/tb_axi_dc_token_writer.sv
// Self-checking bench for axi_dc_token_writer (BUFFER_WIDTH=8, DATA_WIDTH=32).
// Reference model tracks plain write/read counts and an array of slot contents;
// the expected Johnson codes are generated from the count directly.
module tb_axi_dc_token_writer;

    localparam int W  = 8;
    localparam int DW = 32;

    logic            clk;
    logic            rstn;
    logic            valid;
    logic [DW-1:0]   data;
    logic            ready;
    logic [W-1:0]    writetoken;
    logic [W*DW-1:0] buffer;
    logic [W-1:0]    readpointer;
    logic [3:0]      level;

    axi_dc_token_writer #(
        .BUFFER_WIDTH(W),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .valid_i      (valid),
        .data_i       (data),
        .ready_o      (ready),
        .writetoken_o (writetoken),
        .buffer_o     (buffer),
        .readpointer_i(readpointer),
        .level_o      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: total writes, read pointer as driven, and its two synchronizer stages.
    int          wr_n, rd_drive, rd_s1, rd_sync;
    logic [DW-1:0] mem [W];
    bit          last_acc;

    function automatic logic [W-1:0] enc(input int n);
        int m;
        logic [W-1:0] t;
        m = n % (2 * W);
        for (int i = 0; i < W; i++) begin
            t[i] = (m < W) ? (i < m) : (i >= m - W);
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [W*DW-1:0] obs, input logic [W*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        wr_n = 0; rd_drive = 0; rd_s1 = 0; rd_sync = 0;
        for (int i = 0; i < W; i++) mem[i] = '0;
    endtask

    task automatic check_all(input string tag);
        logic [W*DW-1:0] flat;
        for (int i = 0; i < W; i++) flat[i*DW +: DW] = mem[i];
        chk({tag, "_token"}, writetoken, enc(wr_n));
        chk({tag, "_ready"}, ready, ((wr_n - rd_sync) != W));
        chk({tag, "_level"}, level, wr_n - rd_sync);
        chk({tag, "_buffer"}, buffer, flat);
    endtask

    // One clock: drive read pointer, advance the model with the edge, then compare.
    task automatic step(input string tag);
        last_acc    = valid && ((wr_n - rd_sync) != W);
        readpointer = enc(rd_drive);
        @(posedge clk);
        if (last_acc) begin
            mem[wr_n % W] = data;
            wr_n++;
        end
        rd_sync = rd_s1;
        rd_s1   = rd_drive;
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rstn = 1'b0; valid = 1'b0; data = '0; readpointer = '0;
        model_clear();
        #1;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int lvl_before;
        rstn = 1'b0; valid = 1'b0; data = '0; readpointer = '0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Fill eight slots with the reader idle.
        for (int k = 0; k < W; k++) begin
            valid = 1'b1;
            data  = 32'hA0 + k;
            step("fill");
            chk("fill_tok", writetoken, (1 << (k + 1)) - 1);
        end
        chk("full_ready", ready, 1'b0);
        chk("full_level", level, 8);
        // Ninth beat must be held off.
        data = 32'hA8;
        step("held");
        step("held");
        chk("held_tok", writetoken, 8'hFF);
        chk("held_e0", buffer[0 +: DW], 32'hA0);

        // Reader frees one slot; visible two edges later.
        valid    = 1'b0;
        rd_drive = 1;
        step("rp1_e1");
        chk("rp1_e1_ready", ready, 1'b0);
        step("rp1_e2");
        chk("rp1_e2_ready", ready, 1'b1);
        chk("rp1_e2_level", level, 7);
        valid = 1'b1;
        data  = 32'hB0;
        step("b0");
        chk("b0_tok", writetoken, 8'hFE);
        chk("b0_e0", buffer[0 +: DW], 32'hB0);
        valid = 1'b0;

        // Streaming with the reader trailing two beats behind.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            rd_drive   = (wr_n >= 2) ? wr_n - 2 : 0;
            valid      = 1'b1;
            data       = $urandom;
            lvl_before = int'(level);
            step("stream");
            chk("stream_slot", buffer[(k % W)*DW +: DW], data);
            if (k == 15) chk("stream_wrap_tok", writetoken, 8'h00);
            if (k >= 3) begin
                chk("stream_level", level, 4);
                chk("stream_ready", ready, 1'b1);
            end
            if (k >= 4) chk("same_edge_level", level, lvl_before);
        end
        valid = 1'b0;

        // Asynchronous reset in the middle of traffic.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            valid = 1'b1;
            data  = 32'hC0 + k;
            step("pre_rst");
        end
        chk("pre_rst_level", level, 5);
        rstn = 1'b0;
        readpointer = '0;
        model_clear();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rstn  = 1'b1;
        data  = 32'hD0;
        step("post_rst");
        chk("post_rst_e0", buffer[0 +: DW], 32'hD0);
        chk("post_rst_tok", writetoken, 8'h01);

        // Random traffic with a legal reader: one step at a time, never past the writer.
        valid = 1'b0;
        last_acc = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(valid && !last_acc)) begin
                valid = 1'($urandom_range(0, 1));
                data  = $urandom;
            end
            if (rd_drive < wr_n && $urandom_range(0, 2) != 0) rd_drive++;
            assert (rd_drive <= wr_n && (wr_n - rd_drive) <= W);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
